// File: rtl/get_reg_pkg.sv
// Shared types, ABI register-name tables and the "x<n>" name builder for the
// integer-register name lookup used by the disassembler/trace path.
package get_reg_pkg;

    localparam int NAME_W_MIN = 32;

    typedef logic [31:0] reg_name_t;

    // ASCII names right-justified: last char in [7:0], unused leading bytes zero.
    localparam reg_name_t ABI_NAMES [32] = '{
        32'h7A65726F, 32'h00007261, 32'h00007370, 32'h00006770,
        32'h00007470, 32'h00007430, 32'h00007431, 32'h00007432,
        32'h00007330, 32'h00007331, 32'h00006130, 32'h00006131,
        32'h00006132, 32'h00006133, 32'h00006134, 32'h00006135,
        32'h00006136, 32'h00006137, 32'h00007332, 32'h00007333,
        32'h00007334, 32'h00007335, 32'h00007336, 32'h00007337,
        32'h00007338, 32'h00007339, 32'h00733130, 32'h00733131,
        32'h00007433, 32'h00007434, 32'h00007435, 32'h00007436
    };

    localparam logic [2:0] ABI_LENS [32] = '{
        3'd4, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
        3'd2, 3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2
    };

    function automatic reg_name_t decimal_name(input logic [4:0] idx);
        logic [4:0] tens_v;
        logic [4:0] ones_v;
        tens_v = idx / 5'd10;
        ones_v = idx % 5'd10;
        if (idx < 5'd10) begin
            return {16'h0000, 8'h78, 8'h30 + {3'b000, ones_v}};
        end else begin
            return {8'h00, 8'h78, 8'h30 + {3'b000, tens_v}, 8'h30 + {3'b000, ones_v}};
        end
    endfunction

    function automatic logic [2:0] decimal_len(input logic [4:0] idx);
        return (idx < 5'd10) ? 3'd2 : 3'd3;
    endfunction

endpackage

// File: rtl/get_reg_rom.sv
// Combinational register-index to printable-name lookup, ABI or numeric form.
module get_reg_rom
    import get_reg_pkg::*;
(
    input  logic [4:0]  regnum,
    input  logic        abi_mode,
    output reg_name_t   name,
    output logic [2:0]  len
);

    // Select ABI table entry or build the decimal "x<n>" name.
    always_comb begin
        name = 32'h0000_0000;
        len  = 3'd0;
        if (abi_mode) begin
            name = ABI_NAMES[regnum];
            len  = ABI_LENS[regnum];
        end else begin
            name = decimal_name(regnum);
            len  = decimal_len(regnum);
        end
    end

endmodule

// File: rtl/get_reg.sv
// Registered RV integer-register name lookup: one-cycle latency, one request
// per cycle, outputs hold their last name while no request is presented.
module get_reg
    import get_reg_pkg::*;
#(
    parameter int NAME_W = 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [4:0]        regnum_i,
    input  logic              abi_mode_i,
    output logic              valid_o,
    output logic [NAME_W-1:0] name_o,
    output logic [2:0]        len_o
);

    reg_name_t         rom_name_s;
    logic [2:0]        rom_len_s;
    logic              valid_r;
    logic [NAME_W-1:0] name_r;
    logic [2:0]        len_r;

    get_reg_rom u_rom (
        .regnum   (regnum_i),
        .abi_mode (abi_mode_i),
        .name     (rom_name_s),
        .len      (rom_len_s)
    );

    // Output pipeline stage; reset drops any request presented with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            name_r  <= '0;
            len_r   <= 3'd0;
        end else begin
            valid_r <= valid_i;
            if (valid_i) begin
                name_r <= NAME_W'(rom_name_s);
                len_r  <= rom_len_s;
            end else begin
                name_r <= name_r;
                len_r  <= len_r;
            end
        end
    end

    assign valid_o = valid_r;
    assign name_o  = name_r;
    assign len_o   = len_r;

endmodule

// File: tb/tb_get_reg.sv
// Directed self-checking bench for get_reg; expected names come from ASCII
// strings converted to right-justified byte vectors inside the bench.
module tb_get_reg;

    localparam int NAME_W = 33;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_i;
    logic [4:0]        regnum_i;
    logic              abi_mode_i;
    logic              valid_o;
    logic [NAME_W-1:0] name_o;
    logic [2:0]        len_o;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    string abi_tab [32] = '{
        "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
        "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
        "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
        "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"
    };

    logic [4:0]  bb_idx  [4] = '{5'd1, 5'd2, 5'd10, 5'd26};
    logic [31:0] bb_name [4] = '{32'h7261, 32'h7370, 32'h6130, 32'h733130};
    logic [2:0]  bb_len  [4] = '{3'd2, 3'd2, 3'd2, 3'd3};

    get_reg #(.NAME_W(NAME_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .regnum_i   (regnum_i),
        .abi_mode_i (abi_mode_i),
        .valid_o    (valid_o),
        .name_o     (name_o),
        .len_o      (len_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] str_bits(string s);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < s.len(); i++) begin
            v = {v[23:0], 8'(s[i])};
        end
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic expect_name(string tag, logic [31:0] exp_name, logic [2:0] exp_len);
        chk({tag, " valid"}, 64'(valid_o), 64'd1);
        chk({tag, " name"}, 64'(name_o), 64'(exp_name));
        chk({tag, " len"}, 64'(len_o), 64'(exp_len));
        chk({tag, " msb"}, 64'(name_o[NAME_W-1:32]), 64'd0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string s;

        // Reset asserted together with a request: request must be dropped.
        reset      = 1'b1;
        valid_i    = 1'b1;
        regnum_i   = 5'd1;
        abi_mode_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst valid", 64'(valid_o), 64'd0);
            chk("rst name", 64'(name_o), 64'd0);
            chk("rst len", 64'(len_o), 64'd0);
        end

        reset    = 1'b0;
        regnum_i = 5'd0;
        cycle();
        expect_name("zero", 32'h7A65726F, 3'd4);

        for (int i = 0; i < 4; i++) begin
            regnum_i = bb_idx[i];
            cycle();
            expect_name($sformatf("b2b%0d", i), bb_name[i], bb_len[i]);
        end

        abi_mode_i = 1'b0;
        regnum_i   = 5'd5;
        cycle();
        expect_name("x5", 32'h7835, 3'd2);
        regnum_i = 5'd31;
        cycle();
        expect_name("x31", 32'h783331, 3'd3);

        for (int m = 1; m >= 0; m--) begin
            for (int i = 0; i < 32; i++) begin
                abi_mode_i = m[0];
                regnum_i   = 5'(i);
                cycle();
                s = (m == 1) ? abi_tab[i] : $sformatf("x%0d", i);
                expect_name({"sweep ", s}, str_bits(s), 3'(s.len()));
            end
        end

        // Last request was x31; idle cycles must hold it.
        valid_i    = 1'b0;
        abi_mode_i = 1'b1;
        regnum_i   = 5'd3;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("hold valid", 64'(valid_o), 64'd0);
            chk("hold name", 64'(name_o), 64'h783331);
            chk("hold len", 64'(len_o), 64'd3);
        end

        reset    = 1'b1;
        valid_i  = 1'b1;
        regnum_i = 5'd0;
        cycle();
        chk("rst2 valid", 64'(valid_o), 64'd0);
        chk("rst2 name", 64'(name_o), 64'd0);
        chk("rst2 len", 64'(len_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
